// File: rtl/axi_wr_burst_gen.sv
// Splits a linear write request into AXI3 INCR bursts (<=16 beats, no 4KB crossing) plus per-burst W commands.
// Latency: first AW/wcmd valid one cycle after the request handshake; one burst per cycle when both readies are held high.
// Backpressure: AW and wcmd handshake independently; the next burst waits for both; req_ready is low until the done pulse has passed.
module axi_wr_burst_gen #(
    parameter int ID_MAX_WIDTH = 16,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_BYTES   = 8,
    parameter int BEATS_WIDTH  = 16,
    parameter int QOS          = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [BEATS_WIDTH-1:0]  req_beats,
    input  logic [ID_MAX_WIDTH-1:0] req_id,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [ID_MAX_WIDTH-1:0] awid,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [3:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awbrust,
    output logic [1:0]              awlock,
    output logic [3:0]              awcache,
    output logic [2:0]              awprot,
    output logic [3:0]              awqos,
    output logic                    wcmd_valid,
    input  logic                    wcmd_ready,
    output logic [3:0]              wcmd_len,
    output logic                    wcmd_last,
    output logic                    done
);

    localparam int SZ = $clog2(DATA_BYTES);
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(DATA_BYTES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   cur_addr, cur_addr_nxt;
    logic [BEATS_WIDTH-1:0]  remaining, remaining_nxt;
    logic [ID_MAX_WIDTH-1:0] id_q, id_nxt;
    logic                    aw_done, aw_done_nxt;
    logic                    w_done, w_done_nxt;
    logic [12:0]             bytes_to_4k;
    logic [12:0]             beats_to_4k;
    logic [4:0]              cap;
    logic [4:0]              burst_beats;
    logic                    aw_hs, w_hs;

    assign awsize  = 3'(SZ);
    assign awbrust = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'b0011;
    assign awprot  = 3'b000;
    assign awqos   = 4'(QOS);
    assign awid    = id_q;
    assign awaddr  = cur_addr;
    assign wcmd_len = awlen;

    // cur_addr is always beat-aligned, so bytes_to_4k is an exact multiple of DATA_BYTES
    always_comb begin
        bytes_to_4k = 13'h1000 - {1'b0, cur_addr[11:0]};
        beats_to_4k = bytes_to_4k >> SZ;
        cap         = (beats_to_4k < 13'd16) ? beats_to_4k[4:0] : 5'd16;
        burst_beats = (remaining < BEATS_WIDTH'(cap)) ? remaining[4:0] : cap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            id_q      <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cur_addr  <= cur_addr_nxt;
            remaining <= remaining_nxt;
            id_q      <= id_nxt;
            aw_done   <= aw_done_nxt;
            w_done    <= w_done_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cur_addr_nxt  = cur_addr;
        remaining_nxt = remaining;
        id_nxt        = id_q;
        aw_done_nxt   = aw_done;
        w_done_nxt    = w_done;
        req_ready     = 1'b0;
        awvalid       = 1'b0;
        wcmd_valid    = 1'b0;
        awlen         = 4'd0;
        wcmd_last     = 1'b0;
        done          = 1'b0;
        aw_hs         = 1'b0;
        w_hs          = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_beats == '0) begin
                        state_nxt = DONE;
                    end else begin
                        cur_addr_nxt  = req_addr & ~LOW_MASK;
                        remaining_nxt = req_beats;
                        id_nxt        = req_id;
                        aw_done_nxt   = 1'b0;
                        w_done_nxt    = 1'b0;
                        state_nxt     = ISSUE;
                    end
                end
            end
            ISSUE: begin
                awvalid     = !aw_done;
                wcmd_valid  = !w_done;
                awlen       = 4'(burst_beats - 5'd1);
                wcmd_last   = (remaining == BEATS_WIDTH'(burst_beats));
                aw_hs       = awvalid & awready;
                w_hs        = wcmd_valid & wcmd_ready;
                aw_done_nxt = aw_done | aw_hs;
                w_done_nxt  = w_done | w_hs;
                // both sides accepted: retire this burst and move to the next
                if (aw_done_nxt && w_done_nxt) begin
                    aw_done_nxt   = 1'b0;
                    w_done_nxt    = 1'b0;
                    cur_addr_nxt  = cur_addr + (ADDR_WIDTH'(burst_beats) << SZ);
                    remaining_nxt = remaining - BEATS_WIDTH'(burst_beats);
                    if (wcmd_last) state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
